ksa_pipe: RTL and testbench
===========================

KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 Parameter: N, default 16, operand width; power of two, 2..64.
REQ-002 Parameter: TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-003 Derived constant: LVL = log2(N), number of Kogge-Stone prefix levels; LAT = LVL + 2, the pipeline latency in cycles.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 in_valid  in  1  operand set present.
REQ-007 in_ready  out  1  block can accept an operand set this cycle.
REQ-008 a, b  in  N each  operands.
REQ-009 cin  in  1  carry-in.
REQ-010 sub  in  1  0 = add, 1 = subtract.
REQ-011 tag  in  TAG_W  opaque sideband, returned unchanged with the result.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 sum  out  N  result.
REQ-015 cout  out  1  carry out of bit N-1.
REQ-016 out_tag  out  TAG_W  tag of the operation producing this result.
REQ-017 ovf  out  1  signed overflow; present only under KSA_PIPE_OVF_EN.

Function
REQ-018 Effective operands SHALL be: be = b XOR {N{sub}}, ce = cin XOR sub, so sub=1, cin=0 yields a-b; result {cout,sum} = a + be + ce, modulo 2^(N+1).
REQ-019 Stage 0 SHALL register bitwise p = a^be, g = a&be, with ce folded into g[0] as g[0] | (p[0]&ce), plus ce, tag and a valid bit.
REQ-020 Stages 1..LVL SHALL each register one prefix level; level k combines bit i with bit i-2^(k-1) for i >= 2^(k-1) as G = g | (p&g'), P = p&p', and passes lower bits through unchanged.
REQ-021 The final stage SHALL register sum[0] = p0[0]^ce, sum[i] = p0[i]^G[i-1] for i >= 1, and cout = G[N-1]; p0 SHALL be carried down the pipeline for this purpose.
REQ-022 A set accepted on edge k (in_valid & in_ready) SHALL appear with out_valid=1 after edge k+LAT when no stall occurs, e.g. LAT = 6 for N=16.
REQ-023 Stall: in_ready = out_ready | ~out_valid (combinational); when in_ready=0, every stage SHALL hold its contents.
REQ-024 While not stalled, each stage SHALL advance every cycle; bubbles propagate as valid=0 and the pipeline accepts one set per cycle at full throughput.
REQ-025 out_valid SHALL remain high, and sum/cout/out_tag/ovf SHALL remain stable, until out_ready=1 on a clock edge.
REQ-026 Data fields of invalid stages are don't-care internally but SHALL NOT alter results of valid entries.
REQ-027 Results SHALL emerge in acceptance order; there is no dropping and no duplication.

Reset
REQ-028 While rst=1, all stage valid bits, out_valid, sum, cout, out_tag and ovf SHALL be 0; consequently in_ready=1.
REQ-029 Asserting rst mid-operation SHALL discard all in-flight entries immediately; no result of a pre-reset operation SHALL appear afterwards.
REQ-030 The first set SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro KSA_PIPE_OVF_EN: when defined, ovf is present and equals the carry into bit N-1 XOR cout, pipelined alongside sum.
REQ-032 When KSA_PIPE_OVF_EN is undefined, the ovf port and its logic are absent; all other behaviour is identical.

Verification
REQ-033 N=16: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 6 cycles sum=0x0000, cout=1, ovf=0.
REQ-034 N=16: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x7FFF, b=0x0001, sub=0 -> ovf=1 (with macro).
REQ-035 1000 random back-to-back sets, out_ready randomly toggled -> results match a reference model in order, tags match, and no set is lost while in_ready=0.
REQ-036 Issue 3 sets, assert rst for 1 cycle at cycle 2 -> out_valid stays 0 until new sets arrive; the first new result appears LAT cycles after acceptance.
REQ-037 Rebuild with N=8 and N=64 -> latency is 5 and 8 respectively; exhaustive (N=8) or random (N=64) add/sub checks pass.
REQ-038 out_ready=0 held for 10 cycles with the pipeline full -> exactly LAT+1 sets are held, outputs are stable, in_ready=0, and all are delivered in order after release.

Source files
------------

// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe.
// The ovf wire exists only when KSA_PIPE_OVF_EN is defined.
interface ksa_pipe_if #(
   parameter int N     = 16,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     a;
   logic [N-1:0]     b;
   logic             cin;
   logic             sub;
   logic [TAG_W-1:0] tag;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     sum;
   logic             cout;
   logic [TAG_W-1:0] out_tag;
`ifdef KSA_PIPE_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, tag, out_ready,
      input  in_ready, out_valid, sum, cout, out_tag, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, sub, tag, out_ready,
      output in_ready, out_valid, sum, cout, out_tag, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, sub, tag, out_ready,
      input  in_ready, out_valid, sum, cout, out_tag
   );
   modport slave (
      input  in_valid, a, b, cin, sub, tag, out_ready,
      output in_ready, out_valid, sum, cout, out_tag
   );
`endif
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone add/subtract: stage 0 p/g, log2(N) prefix stages, one sum stage.
// Optional signed-overflow output under macro KSA_PIPE_OVF_EN.
module ksa_pipe #(
   parameter int N     = 16,
   parameter int TAG_W = 4
) (
   input  logic      clk,
   input  logic      rst,
   ksa_pipe_if.slave bus
);
   localparam int LVL = $clog2(N);

   logic                      stage_en;
   logic [N-1:0]              be;
   logic                      ce_in;

   logic [LVL:0][N-1:0]       g_d, g_q;
   logic [LVL-1:0][N-1:0]     p_d, p_q;
   logic [LVL:0][N-1:0]       p0_d, p0_q;
   logic [LVL:0]              ce_d, ce_q;
   logic [LVL:0]              vld_d, vld_q;
   logic [LVL:0][TAG_W-1:0]   tag_d, tag_q;

   logic [N-1:0]              sum_d, sum_q;
   logic                      cout_d, cout_q;
   logic                      out_vld_q;
   logic [TAG_W-1:0]          out_tag_q;

   // One global enable: the whole pipe freezes while the output is blocked.
   assign stage_en = bus.out_ready | ~out_vld_q;

   assign be    = bus.b ^ {N{bus.sub}};
   assign ce_in = bus.cin ^ bus.sub;

   assign p_d[0]   = bus.a ^ be;
   assign g_d[0]   = (bus.a & be) | {{(N-1){1'b0}}, (bus.a[0] ^ be[0]) & ce_in};
   assign p0_d[0]  = bus.a ^ be;
   assign ce_d[0]  = ce_in;
   assign vld_d[0] = bus.in_valid;
   assign tag_d[0] = bus.tag;

   genvar gl, gi;
   generate
      for (gl = 1; gl <= LVL; gl++) begin : g_lvl
         localparam int D = 1 << (gl - 1);
         for (gi = 0; gi < N; gi++) begin : g_bit
            if (gi >= D) begin : g_comb
               assign g_d[gl][gi] = g_q[gl-1][gi] | (p_q[gl-1][gi] & g_q[gl-1][gi-D]);
               if (gl < LVL) begin : g_p
                  assign p_d[gl][gi] = p_q[gl-1][gi] & p_q[gl-1][gi-D];
               end
            end else begin : g_pass
               assign g_d[gl][gi] = g_q[gl-1][gi];
               if (gl < LVL) begin : g_p
                  assign p_d[gl][gi] = p_q[gl-1][gi];
               end
            end
         end
         assign p0_d[gl]  = p0_q[gl-1];
         assign ce_d[gl]  = ce_q[gl-1];
         assign vld_d[gl] = vld_q[gl-1];
         assign tag_d[gl] = tag_q[gl-1];
      end
   endgenerate

   // g already includes the carry-in, so G[i-1] is the carry into bit i.
   assign sum_d  = p0_q[LVL] ^ {g_q[LVL][N-2:0], ce_q[LVL]};
   assign cout_d = g_q[LVL][N-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         g_q       <= '0;
         p_q       <= '0;
         p0_q      <= '0;
         ce_q      <= '0;
         vld_q     <= '0;
         tag_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         out_vld_q <= 1'b0;
         out_tag_q <= '0;
      end else if (stage_en) begin
         g_q       <= g_d;
         p_q       <= p_d;
         p0_q      <= p0_d;
         ce_q      <= ce_d;
         vld_q     <= vld_d;
         tag_q     <= tag_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         out_vld_q <= vld_q[LVL];
         out_tag_q <= tag_q[LVL];
      end
   end

`ifdef KSA_PIPE_OVF_EN
   logic ovf_d, ovf_q;

   assign ovf_d = g_q[LVL][N-2] ^ g_q[LVL][N-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (stage_en) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.in_ready  = stage_en;
   assign bus.out_valid = out_vld_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_ksa_pipe.sv
// Self-checking bench for ksa_pipe: directed corner cases, random stalled traffic,
// full-pipe stall, and mid-flight reset against an arithmetic reference model.
module tb_ksa_pipe;
   localparam int N     = 16;
   localparam int TAG_W = 4;
   localparam int LVL   = $clog2(N);
   localparam int LAT   = LVL + 2;
   localparam int NUM   = 1000;

   typedef struct packed {
      logic [N-1:0]     sum;
      logic             cout;
      logic [TAG_W-1:0] tag;
      logic             ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   ksa_pipe_if #(.N(N), .TAG_W(TAG_W)) bus ();
   ksa_pipe #(.N(N), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic cin, input logic sub,
                                  input logic [TAG_W-1:0] tag);
      logic [N-1:0] bop;
      logic         cop;
      logic [N:0]   r;
      res_t         x;
      bop   = sub ? ~b : b;
      cop   = cin ^ sub;
      r     = {1'b0, a} + {1'b0, bop} + {{N{1'b0}}, cop};
      x.sum  = r[N-1:0];
      x.cout = r[N];
      x.tag  = tag;
`ifdef KSA_PIPE_OVF_EN
      x.ovf  = (a[N-1] == bop[N-1]) && (r[N-1] != a[N-1]);
`else
      x.ovf  = 1'b0;
`endif
      return x;
   endfunction

   function automatic res_t sample_out();
      res_t r;
      r.sum  = bus.sum;
      r.cout = bus.cout;
      r.tag  = bus.out_tag;
`ifdef KSA_PIPE_OVF_EN
      r.ovf  = bus.ovf;
`else
      r.ovf  = 1'b0;
`endif
      return r;
   endfunction

   function automatic logic [N-1:0] rand_n();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return t[N-1:0];
   endfunction

   function automatic logic [TAG_W-1:0] rand_t();
      logic [31:0] t;
      t = $urandom();
      return t[TAG_W-1:0];
   endfunction

   task automatic drive_set(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin, input logic sub, input logic [TAG_W-1:0] tag);
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.tag      = tag;
   endtask

   task automatic drive_rand();
      drive_set(1'b1, rand_n(), rand_n(), 1'($urandom_range(1)), 1'($urandom_range(1)), rand_t());
   endtask

   // Issue one set into an empty pipe and return its result and observed latency (-1 on timeout).
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic sub, input logic [TAG_W-1:0] tag,
                         output res_t r, output int lat);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive_set(1'b1, a, b, cin, sub, tag);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < LAT + 8) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!bus.out_valid) lat = -1;
      r = sample_out();
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b0;
      drive_set(1'b0, '0, '0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      drive_rand();
      repeat (LAT + 2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      n_checks++;
      if (bus.sum !== '0 || bus.cout !== 1'b0) begin
         n_fail++; $display("FAIL reset_sum_cout: got sum=%h cout=%b expected 0/0", bus.sum, bus.cout);
      end
      n_checks++;
      if (bus.out_tag !== '0) begin
         n_fail++; $display("FAIL reset_out_tag: got %h expected 0", bus.out_tag);
      end
`ifdef KSA_PIPE_OVF_EN
      n_checks++;
      if (bus.ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf);
      end
`endif
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [N-1:0] ones, msb, maxpos;
      logic [N-1:0] ta[6], tbv[6], tsum[6];
      logic         tcin[6], tsub[6], tcout[6], tovf[6];
      res_t         r;
      int           lat;
      ones   = '1;
      maxpos = ones >> 1;
      msb    = ones ^ maxpos;
      ta[0] = ones;   tbv[0] = 1; tcin[0] = 0; tsub[0] = 0; tsum[0] = '0;       tcout[0] = 1; tovf[0] = 0;
      ta[1] = 5;      tbv[1] = 7; tcin[1] = 0; tsub[1] = 1; tsum[1] = ones - 1; tcout[1] = 0; tovf[1] = 0;
      ta[2] = maxpos; tbv[2] = 1; tcin[2] = 0; tsub[2] = 0; tsum[2] = msb;      tcout[2] = 0; tovf[2] = 1;
      ta[3] = 0;      tbv[3] = 0; tcin[3] = 1; tsub[3] = 0; tsum[3] = 1;        tcout[3] = 0; tovf[3] = 0;
      ta[4] = 0;      tbv[4] = 0; tcin[4] = 0; tsub[4] = 1; tsum[4] = '0;       tcout[4] = 1; tovf[4] = 0;
      ta[5] = msb;    tbv[5] = 1; tcin[5] = 0; tsub[5] = 1; tsum[5] = maxpos;   tcout[5] = 1; tovf[5] = 1;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tbv[i], tcin[i], tsub[i], TAG_W'(i + 3), r, lat);
         n_checks++;
         if (lat !== LAT) begin
            n_fail++; $display("FAIL directed[%0d]_latency: got %0d expected %0d", i, lat, LAT);
         end
         n_checks++;
         if (r.sum !== tsum[i] || r.cout !== tcout[i]) begin
            n_fail++; $display("FAIL directed[%0d]_sum: got sum=%h cout=%b expected sum=%h cout=%b",
                               i, r.sum, r.cout, tsum[i], tcout[i]);
         end
         n_checks++;
         if (r.tag !== TAG_W'(i + 3)) begin
            n_fail++; $display("FAIL directed[%0d]_tag: got %h expected %h", i, r.tag, TAG_W'(i + 3));
         end
`ifdef KSA_PIPE_OVF_EN
         n_checks++;
         if (r.ovf !== tovf[i]) begin
            n_fail++; $display("FAIL directed[%0d]_ovf: got %b expected %b", i, r.ovf, tovf[i]);
         end
`endif
         $display("directed[%0d]: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d",
                  i, ta[i], tbv[i], tcin[i], tsub[i], r.sum, r.cout, lat);
      end
   endtask

   task automatic test_back_to_back();
      res_t exp_q[$];
      res_t got, snap;
      logic held, acc;
      int   sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0; held = 1'b0; acc = 1'b1;
      while ((sent < NUM || exp_q.size() > 0 || bus.in_valid) && cyc < 40000) begin
         @(posedge clk); #1;
         cyc++;
         if (acc || !bus.in_valid) begin
            if (sent < NUM && ($urandom_range(7) != 0)) drive_rand();
            else bus.in_valid = 1'b0;
         end
         bus.out_ready = ($urandom_range(2) != 0);
         @(negedge clk);
         n_checks++;
         if (bus.in_ready !== (bus.out_ready | ~bus.out_valid)) begin
            n_fail++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc,
                               bus.in_ready, bus.out_ready | ~bus.out_valid);
         end
         if (bus.out_valid) begin
            got = sample_out();
            if (held) begin
               n_checks++;
               if (got !== snap) begin
                  n_fail++; $display("FAIL b2b_hold cyc %0d: got %h expected %h", cyc, got, snap);
               end
            end
            if (bus.out_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++; $display("FAIL b2b_extra cyc %0d: got result %h expected none", cyc, got);
               end else begin
                  if (got !== exp_q[0]) begin
                     n_fail++; $display("FAIL b2b_result[%0d]: got sum=%h cout=%b tag=%h ovf=%b expected sum=%h cout=%b tag=%h ovf=%b",
                                        recv, got.sum, got.cout, got.tag, got.ovf,
                                        exp_q[0].sum, exp_q[0].cout, exp_q[0].tag, exp_q[0].ovf);
                  end
                  void'(exp_q.pop_front());
                  recv++;
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               snap = got;
            end
         end else begin
            held = 1'b0;
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc) begin
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.tag));
            sent++;
         end
      end
      n_checks++;
      if (recv !== NUM) begin
         n_fail++; $display("FAIL b2b_count: got %0d results expected %0d", recv, NUM);
      end
      $display("back_to_back: sent=%0d received=%0d cycles=%0d", sent, recv, cyc);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_stall();
      res_t exp_q[$];
      res_t got, snap;
      logic stable, acc;
      int   acc_cnt, stall_cyc, recv, cyc;
      acc_cnt = 0; stall_cyc = 0; stable = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      drive_rand();
      for (int c = 0; c < LAT + 10; c++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = sample_out();
            if (stall_cyc == 0) snap = got;
            else if (got !== snap) stable = 1'b0;
            stall_cyc++;
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc) begin
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.tag));
            acc_cnt++;
         end
         @(posedge clk); #1;
         if (acc) drive_rand();
      end
      n_checks++;
      if (acc_cnt + 1 !== LAT + 1) begin
         n_fail++; $display("FAIL stall_held: got %0d sets held expected %0d", acc_cnt + 1, LAT + 1);
      end
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_flags: got in_ready=%b out_valid=%b expected 0/1",
                            bus.in_ready, bus.out_valid);
      end
      n_checks++;
      if (stall_cyc !== 10 || !stable) begin
         n_fail++; $display("FAIL stall_stable: got %0d stalled cycles stable=%b expected 10/1",
                            stall_cyc, stable);
      end
      bus.out_ready = 1'b1;
      recv = 0; cyc = 0;
      while ((exp_q.size() > 0 || bus.in_valid) && cyc < 4 * LAT + 20) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = sample_out();
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stall_extra: got result %h expected none", got);
            end else begin
               if (got !== exp_q[0]) begin
                  n_fail++; $display("FAIL stall_result[%0d]: got %h expected %h", recv, got, exp_q[0]);
               end
               void'(exp_q.pop_front());
               recv++;
            end
         end
         acc = bus.in_valid && bus.in_ready;
         if (acc) exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, bus.tag));
         @(posedge clk); #1;
         if (acc) bus.in_valid = 1'b0;
         cyc++;
      end
      n_checks++;
      if (recv !== LAT + 1) begin
         n_fail++; $display("FAIL stall_count: got %0d results expected %0d", recv, LAT + 1);
      end
      $display("stall: accepted=%0d stalled_cycles=%0d delivered=%0d", acc_cnt, stall_cyc, recv);
   endtask

   task automatic test_reset_mid();
      logic         seen;
      res_t         r, e;
      int           lat;
      logic [N-1:0] a, b;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drive_rand();
      @(posedge clk); #1;
      drive_rand();
      @(posedge clk); #1;
      drive_rand();
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_flags: got out_valid=%b in_ready=%b expected 0/1",
                            bus.out_valid, bus.in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      seen = 1'b0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_stale: got stale out_valid=1 expected 0");
      end
      a = rand_n();
      b = rand_n();
      e = model(a, b, 1'b1, 1'b0, TAG_W'(9));
      run_op(a, b, 1'b1, 1'b0, TAG_W'(9), r, lat);
      n_checks++;
      if (lat !== LAT) begin
         n_fail++; $display("FAIL rst_mid_latency: got %0d expected %0d", lat, LAT);
      end
      n_checks++;
      if (r !== e) begin
         n_fail++; $display("FAIL rst_mid_result: got %h expected %h", r, e);
      end
      $display("reset_mid: stale_seen=%b new_lat=%0d sum=%h", seen, lat, r.sum);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
